// File: rtl/rx_sync_ctrl_10b8b.sv
// Receive-side 10b/8b link controller: tracks running disparity for the decoder,
// acquires comma-based word sync and forwards decoded bytes while sync is held.
module rx_sync_ctrl_10b8b #(
    parameter int COMMA_CNT = 3,
    parameter int ERR_LIMIT = 4,
    parameter int GOOD_RUN  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [9:0]           sym_in,
    input  logic                 sym_valid,
    output logic                 rdisp_out,
    input  logic [7:0]           dec_data,
    input  logic                 dec_k,
    input  logic                 dec_code_err,
    input  logic                 dec_disp_err,
    output logic [7:0]           rx_data,
    output logic                 rx_k,
    output logic                 rx_valid,
    output logic                 sync_ok,
    output logic                 los_event,
    output logic [ERR_CNT_W-1:0] err_total
);

    localparam logic [1:0] ST_LOS  = 2'd0;
    localparam logic [1:0] ST_CD   = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;

    localparam logic [2:0] COMMA_TGT = 3'(COMMA_CNT);
    localparam logic [2:0] ERR_TGT   = 3'(ERR_LIMIT);
    localparam logic [3:0] GOOD_TGT  = 4'(GOOD_RUN);
    localparam logic [7:0] K28_5     = 8'hBC;

    logic [1:0] state, state_nx;
    logic [2:0] comma_cnt, comma_cnt_nx;
    logic [2:0] err_acc, err_acc_nx;
    logic [3:0] good_cnt, good_cnt_nx;
    logic       rd;
    logic       v_d;
    logic [3:0] ones;
    logic       is_bad;
    logic       is_comma;
    logic       los_nx;
    logic       err_inc;
    logic       fwd;

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + 4'(sym_in[i]);
        end
    end

    // Disparity errors still count as commas so acquisition tolerates a bad RD guess.
    always_comb begin
        is_bad   = dec_code_err | dec_disp_err;
        is_comma = dec_k & (dec_data == K28_5) & ~dec_code_err;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx     = state;
        comma_cnt_nx = comma_cnt;
        err_acc_nx   = err_acc;
        good_cnt_nx  = good_cnt;
        los_nx       = 1'b0;
        err_inc      = 1'b0;

        if (!enable) begin
            state_nx     = ST_LOS;
            comma_cnt_nx = 3'd0;
            err_acc_nx   = 3'd0;
            good_cnt_nx  = 4'd0;
            los_nx       = (state == ST_SYNC);
        end else if (v_d) begin
            case (state)
                ST_LOS: begin
                    if (is_comma) begin
                        state_nx     = ST_CD;
                        comma_cnt_nx = 3'd1;
                    end
                end
                ST_CD: begin
                    if (is_comma) begin
                        if (comma_cnt + 3'd1 == COMMA_TGT) begin
                            state_nx     = ST_SYNC;
                            comma_cnt_nx = 3'd0;
                            err_acc_nx   = 3'd0;
                            good_cnt_nx  = 4'd0;
                        end else begin
                            comma_cnt_nx = comma_cnt + 3'd1;
                        end
                    end else if (dec_code_err) begin
                        state_nx     = ST_LOS;
                        comma_cnt_nx = 3'd0;
                    end
                end
                ST_SYNC: begin
                    if (is_bad) begin
                        err_inc     = 1'b1;
                        good_cnt_nx = 4'd0;
                        if (err_acc + 3'd1 == ERR_TGT) begin
                            state_nx   = ST_LOS;
                            err_acc_nx = 3'd0;
                            los_nx     = 1'b1;
                        end else begin
                            err_acc_nx = err_acc + 3'd1;
                        end
                    end else if (good_cnt + 4'd1 == GOOD_TGT) begin
                        good_cnt_nx = 4'd0;
                        err_acc_nx  = (err_acc == 3'd0) ? 3'd0 : err_acc - 3'd1;
                    end else begin
                        good_cnt_nx = good_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nx     = ST_LOS;
                    comma_cnt_nx = 3'd0;
                    err_acc_nx   = 3'd0;
                    good_cnt_nx  = 4'd0;
                end
            endcase
        end
    end

    // Forwarding follows the state the symbol was judged in, so the symbol that
    // drops sync still reaches the link layer.
    assign fwd = enable & v_d & (state == ST_SYNC);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_LOS;
            comma_cnt <= 3'd0;
            err_acc   <= 3'd0;
            good_cnt  <= 4'd0;
            rd        <= 1'b0;
            v_d       <= 1'b0;
            rx_data   <= 8'd0;
            rx_k      <= 1'b0;
            rx_valid  <= 1'b0;
            los_event <= 1'b0;
            err_total <= '0;
        end else begin
            state     <= state_nx;
            comma_cnt <= comma_cnt_nx;
            err_acc   <= err_acc_nx;
            good_cnt  <= good_cnt_nx;
            los_event <= los_nx;
            v_d       <= enable & sym_valid;
            rx_valid  <= fwd;

            if (!enable) begin
                rd <= 1'b0;
            end else if (sym_valid) begin
                if (ones == 4'd6) begin
                    rd <= 1'b1;
                end else if (ones == 4'd4) begin
                    rd <= 1'b0;
                end
            end

            if (fwd) begin
                rx_data <= dec_data;
                rx_k    <= dec_k;
            end

            if (err_inc && (err_total != '1)) begin
                err_total <= err_total + ERR_CNT_W'(1);
            end
        end
    end

    assign rdisp_out = rd;
    assign sync_ok   = (state == ST_SYNC);

endmodule

// File: tb/tb_rx_sync_ctrl_10b8b.sv
// Bench for rx_sync_ctrl_10b8b: plays the registered decoder, runs directed link
// scenarios then random traffic against a cycle-level reference model.
module tb_rx_sync_ctrl_10b8b;

    localparam int COMMA_CNT = 3;
    localparam int ERR_LIMIT = 4;
    localparam int GOOD_RUN  = 4;
    localparam int EW        = 4;
    localparam int TOT_MAX   = (1 << EW) - 1;

    localparam logic [9:0] K285_N  = 10'b0011111010;
    localparam logic [9:0] K285_P  = 10'b1100000101;
    localparam logic [9:0] D215    = 10'b1010101010;
    localparam logic [9:0] D102    = 10'b0101010101;
    localparam logic [9:0] K280_N  = 10'b0011110100;
    localparam logic [9:0] K280_P  = 10'b1100001011;
    localparam logic [9:0] INVALID = 10'b1111111111;

    typedef struct packed {
        logic [9:0] sym;
        logic [7:0] data;
        logic       k;
        logic       cerr;
        logic       derr;
    } rec_t;

    typedef enum int {M_LOS, M_CD, M_SYNC} mstate_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [9:0]    sym_in;
    logic          sym_valid;
    logic          rdisp_out;
    logic [7:0]    dec_data;
    logic          dec_k;
    logic          dec_code_err;
    logic          dec_disp_err;
    logic [7:0]    rx_data;
    logic          rx_k;
    logic          rx_valid;
    logic          sync_ok;
    logic          los_event;
    logic [EW-1:0] err_total;

    int errors = 0;
    int checks = 0;

    mstate_t m_st;
    int      m_cc, m_ea, m_gc, m_rd, e_tot;
    bit      m_vd, e_rxv, e_rxk, e_los;
    logic [7:0] e_rxd;

    always #5 clk = ~clk;

    rx_sync_ctrl_10b8b #(
        .COMMA_CNT (COMMA_CNT),
        .ERR_LIMIT (ERR_LIMIT),
        .GOOD_RUN  (GOOD_RUN),
        .ERR_CNT_W (EW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .rdisp_out    (rdisp_out),
        .dec_data     (dec_data),
        .dec_k        (dec_k),
        .dec_code_err (dec_code_err),
        .dec_disp_err (dec_disp_err),
        .rx_data      (rx_data),
        .rx_k         (rx_k),
        .rx_valid     (rx_valid),
        .sync_ok      (sync_ok),
        .los_event    (los_event),
        .err_total    (err_total)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock, applying the link rules to the
    // decoder result currently presented and to the symbol being sampled.
    task automatic model_step(input bit r, input bit en, input bit sv, input logic [9:0] s);
        bit bad, comma;
        if (!r) begin
            m_st = M_LOS; m_cc = 0; m_ea = 0; m_gc = 0; m_rd = 0; m_vd = 0;
            e_rxv = 0; e_rxd = 8'd0; e_rxk = 0; e_los = 0; e_tot = 0;
            return;
        end
        e_los = 0;
        e_rxv = 0;
        if (!en) begin
            e_los = (m_st == M_SYNC);
            m_st = M_LOS; m_cc = 0; m_ea = 0; m_gc = 0; m_rd = 0; m_vd = 0;
            return;
        end
        if (m_vd) begin
            bad   = dec_code_err || dec_disp_err;
            comma = dec_k && (dec_data == 8'hBC) && !dec_code_err;
            if (m_st == M_SYNC) begin
                e_rxv = 1; e_rxd = dec_data; e_rxk = dec_k;
            end
            case (m_st)
                M_LOS: if (comma) begin m_st = M_CD; m_cc = 1; end
                M_CD: begin
                    if (comma) begin
                        m_cc++;
                        if (m_cc == COMMA_CNT) begin m_st = M_SYNC; m_ea = 0; m_gc = 0; end
                    end else if (dec_code_err) begin
                        m_st = M_LOS;
                    end
                end
                M_SYNC: begin
                    if (bad) begin
                        m_ea++; m_gc = 0;
                        if (e_tot < TOT_MAX) e_tot++;
                        if (m_ea == ERR_LIMIT) begin m_st = M_LOS; e_los = 1; end
                    end else begin
                        m_gc++;
                        if (m_gc == GOOD_RUN) begin
                            m_gc = 0;
                            if (m_ea > 0) m_ea--;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (sv) begin
            case ($countones(s))
                6: m_rd = 1;
                4: m_rd = 0;
                default: ;
            endcase
        end
        m_vd = sv;
    endtask

    task automatic check_outputs();
        check("sync_ok", sync_ok, (m_st == M_SYNC));
        check("rdisp_out", rdisp_out, m_rd);
        check("rx_valid", rx_valid, e_rxv);
        check("los_event", los_event, e_los);
        check("err_total", err_total, e_tot);
        if (e_rxv) begin
            check("rx_data", rx_data, e_rxd);
            check("rx_k", rx_k, e_rxk);
        end
    endtask

    function automatic rec_t mk(input logic [9:0] s, input logic [7:0] d, input logic k,
                                input logic ce, input logic de);
        rec_t x;
        x.sym = s; x.data = d; x.k = k; x.cerr = ce; x.derr = de;
        return x;
    endfunction

    function automatic rec_t comma_ok();
        return mk(m_rd != 0 ? K285_P : K285_N, 8'hBC, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic rec_t garbage();
        logic [7:0] d;
        d = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'($urandom);
        return mk(10'($urandom), d, 1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    function automatic rec_t pick_sym();
        int p;
        p = $urandom_range(0, 99);
        if (p < 30) return comma_ok();
        if (p < 35) return mk(m_rd != 0 ? K285_N : K285_P, 8'hBC, 1'b1, 1'b0, 1'b1);
        if (p < 55) return mk(D215, 8'hB5, 1'b0, 1'b0, 1'b0);
        if (p < 65) return mk(D102, 8'h4A, 1'b0, 1'b0, 1'b0);
        if (p < 75) return mk(m_rd != 0 ? K280_P : K280_N, 8'h1C, 1'b1, 1'b0, 1'b0);
        if (p < 85) return mk(INVALID, 8'($urandom), 1'($urandom), 1'b1, 1'b0);
        if (p < 90) return mk(10'($urandom), 8'hBC, 1'b1, 1'b1, 1'b0);
        return mk(10'($urandom), 8'($urandom), 1'b0, 1'b1, 1'($urandom));
    endfunction

    // Drive one cycle at the falling edge, let the DUT and the stand-in decoder
    // register it, then compare at the next falling edge.
    task automatic step(input bit r, input bit en, input bit sv, input rec_t s);
        rst_n = r; enable = en; sym_valid = sv; sym_in = s.sym;
        model_step(r, en, sv, s.sym);
        @(posedge clk);
        @(negedge clk);
        dec_data = s.data; dec_k = s.k; dec_code_err = s.cerr; dec_disp_err = s.derr;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, garbage());
    endtask

    task automatic send(input rec_t s, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, s);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, garbage());
        step(1'b0, 1'b1, 1'b0, garbage());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rec_t bad_sym, d215_sym;
        bad_sym  = mk(INVALID, 8'h00, 1'b0, 1'b1, 1'b0);
        d215_sym = mk(D215, 8'hB5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0; enable = 1'b1; sym_valid = 1'b0; sym_in = 10'd0;
        dec_data = 8'd0; dec_k = 1'b0; dec_code_err = 1'b0; dec_disp_err = 1'b0;
        @(negedge clk);

        do_reset();
        check("reset_sync_ok", sync_ok, 0);
        check("reset_rdisp", rdisp_out, 0);
        check("reset_err_total", err_total, 0);

        // acquire: RD toggles 1,0,1 and sync follows two cycles after comma 3
        send(comma_ok(), 1); check("acq_rd1", rdisp_out, 1);
        send(comma_ok(), 1); check("acq_rd2", rdisp_out, 0);
        send(comma_ok(), 1); check("acq_rd3", rdisp_out, 1);
        check("acq_not_yet", sync_ok, 0);
        idle(1);
        check("acq_sync", sync_ok, 1);

        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, (i < 4), d215_sym);
            if (rx_valid && rx_data == 8'hB5 && !rx_k) cnt++;
        end
        check("fwd_count", cnt, 4);
        check("fwd_rd_held", rdisp_out, 1);

        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, (i < 4), bad_sym);
            if (los_event) cnt++;
        end
        check("los_pulses", cnt, 1);
        check("los_sync_ok", sync_ok, 0);
        check("los_err_total", err_total, 4);

        // forgiveness: err_acc 3 -> 2 -> 3 keeps sync
        do_reset();
        send(comma_ok(), 3);
        idle(2);
        send(bad_sym, 3);
        send(d215_sym, 4);
        send(bad_sym, 1);
        idle(2);
        check("forgive_sync", sync_ok, 1);
        check("forgive_err_total", err_total, 4);

        // abort during comma detect
        do_reset();
        send(comma_ok(), 2);
        idle(1);
        step(1'b1, 1'b0, 1'b1, comma_ok());
        check("abort_sync_ok", sync_ok, 0);
        check("abort_rdisp", rdisp_out, 0);
        send(comma_ok(), 2);
        idle(3);
        check("abort_two_commas", sync_ok, 0);
        send(comma_ok(), 1);
        idle(2);
        check("abort_resync", sync_ok, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, en, sv;
            r  = ($urandom_range(0, 999) >= 5);
            en = ($urandom_range(0, 99) >= 3);
            sv = ($urandom_range(0, 99) < 85);
            step(r, en, sv, sv ? pick_sym() : garbage());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_sync_ctrl_10b8b.md
# rx_sync_ctrl_10b8b

Receive-side link controller that sequences the 10b/8b decoder on the IEEE 1149.10 receive path. It tracks running disparity from the raw 10-bit symbol stream and drives the decoder's disparity input. It runs a comma-based word-sync state machine on the decoder's registered results and forwards decoded bytes only while sync is held. It also counts symbol errors and reports loss-of-sync events to the link layer.

## Interface
Parameters:
- COMMA_CNT, 3: consecutive valid commas required to declare sync (range 2..7).
- ERR_LIMIT, 4: accumulated bad symbols in SYNC that cause loss of sync (range 2..7).
- GOOD_RUN, 4: consecutive good symbols that forgive one bad symbol (range 2..15).
- ERR_CNT_W, 16: width of the saturating total-error counter.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: controller enable; low forces the LOS state.
- sym_in, input, 10: raw symbol, also fed to the decoder's data_in in the same cycle.
- sym_valid, input, 1: sym_in holds a new symbol this cycle.
- rdisp_out, output, 1: running disparity before sym_in (1 = RD+); wired to the decoder's rdisp_in.
- dec_data, input, 8: decoder data_out.
- dec_k, input, 1: decoder k_out.
- dec_code_err, input, 1: decoder code_err.
- dec_disp_err, input, 1: decoder disp_err.
- rx_data, output, 8: forwarded byte.
- rx_k, output, 1: forwarded K flag.
- rx_valid, output, 1: rx_data/rx_k valid; asserted only in SYNC.
- sync_ok, output, 1: high in the SYNC state.
- los_event, output, 1: one-cycle pulse on each SYNC→LOS transition.
- err_total, output, ERR_CNT_W: saturating count of bad symbols seen while in SYNC.

## Operation
- **Running disparity:** on a cycle with sym_valid, compute ones = popcount(sym_in).
  - ones = 6 → RD+.
  - ones = 4 → RD−.
  - ones = 5 → RD unchanged.
  - Any other count → RD unchanged (the decoder flags it).
  - RD is a register, so rdisp_out always reflects the disparity before the current symbol.
- **Qualification:** v_d = sym_valid delayed one cycle; it qualifies the dec_* inputs, which the decoder registers.
- **Symbol classes** (evaluated only when v_d = 1):
  - bad = dec_code_err | dec_disp_err.
  - comma = dec_k & (dec_data == 8'hBC) & !dec_code_err. Disparity errors are ignored for comma detection in LOS and CD.
  - good = !bad.
- **Sync FSM:** states LOS, CD (comma-detect, with comma_cnt), SYNC.
  - **LOS:** comma → CD with comma_cnt = 1; anything else → stay in LOS.
  - **CD:**
    - comma → comma_cnt+1; reaching COMMA_CNT → SYNC with err_acc = 0 and good_cnt = 0.
    - dec_code_err → LOS.
    - Other valid non-comma symbol → stay, count held.
  - **SYNC:**
    - bad → err_acc+1 and good_cnt = 0; if err_acc+1 == ERR_LIMIT → LOS and pulse los_event.
    - good → good_cnt+1; on reaching GOOD_RUN, good_cnt = 0 and err_acc = err_acc−1 (floor 0).
- **Forwarding:** in SYNC with v_d, rx_data = dec_data, rx_k = dec_k, rx_valid = 1. Bad symbols are forwarded too, with rx_valid = 1, so the link layer sees them.
- **err_total:** increments on every bad symbol in SYNC and saturates at all-ones. It is cleared only by reset.
- **enable = 0:** next state LOS, RD reset to RD−, counters cleared, rx_valid = 0, err_total held. If the controller was in SYNC, los_event pulses.

## Timing
- **Reset (rst_n = 0 at an edge):**
  - State LOS; rdisp_out = 0; rx_data = 0; rx_k = 0; rx_valid = 0; sync_ok = 0; los_event = 0; err_total = 0.
  - Internal comma_cnt, err_acc, good_cnt and v_d are cleared.
- **RD:** a symbol at cycle t updates rdisp_out at t+1. Back-to-back symbols are supported every cycle.
- **Decoder results:** the decoder result for the symbol at t is sampled at t+1. The FSM state, sync_ok and rx_* update at t+2, giving a latency of 2 cycles from sym_in to rx_valid.
- **sync_ok:** rises at t+2 relative to the COMMA_CNT-th comma presented at t. It falls at t+2 relative to the symbol that pushes err_acc to ERR_LIMIT. los_event pulses in that same cycle.
- **Gaps:** idle cycles (sym_valid = 0) change nothing: RD, counters and state are held, and rx_valid = 0 two cycles later.
- **Simultaneous events:**
  - Reset dominates enable.
  - enable = 0 dominates a symbol in the same cycle, and that symbol is discarded.
  - A bad symbol that also completes a GOOD_RUN window cannot occur, because bad zeroes good_cnt first.
- **Reset mid-operation:** takes effect at the next edge regardless of pipeline contents, and in-flight decoder results are dropped.

## Test plan
The bench instantiates the decoder with this block, feeding sym_in to both and wiring rdisp_out to rdisp_in.
- **Reset:** hold rst_n = 0 for 2 cycles → all outputs 0, state LOS, rdisp_out = 0.
- **Sync acquire:** send K28.5 alternating 0011111010, 1100000101, 0011111010 → rdisp_out toggles 0→1→0→1; sync_ok = 1 two cycles after the 3rd comma; no rx_valid before that.
- **Data forwarding:** in SYNC, send D21.5 1010101010 ×4 → rx_data = 8'hB5, rx_k = 0, rx_valid = 1 each, at 2-cycle latency; RD unchanged.
- **Loss of sync:** in SYNC, send 4 invalid symbols 1111111111 → err_total = 4; sync_ok falls; los_event is high for exactly 1 cycle.
- **Forgiveness:** in SYNC, send 3 bad symbols, then 4 good, then 1 bad → still in sync (err_acc 3→2→3); err_total = 4.
- **Abort:** drop enable during CD after 2 commas → LOS next cycle, rdisp_out = 0; a subsequent 3 commas are needed to sync.
